// File: rtl/pair_match_pkg.sv
// Shared types and helpers for the pairwise match-matrix sequencer.
// Holds the FSM state encoding, the default vector width and a popcount helper.
package pair_match_pkg;

    localparam int N_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Rows are at most 8 bits wide; narrower rows are zero-extended by the caller.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pair_match_row.sv
// One row of the match matrix: element idx XNORed against every element of the vector.
// Purely combinational; element 0 sits in the MSB.
module pair_match_row #(
    parameter int N = 5
) (
    input  logic [N-1:0] vec,
    input  logic [2:0]   idx,
    output logic [N-1:0] row
);

    logic sel;

    always_comb begin
        sel = 1'b0;
        if (int'(idx) < N) begin
            sel = vec[N-1-int'(idx)];
        end
        row = {N{sel}} ~^ vec;
    end

endmodule

// File: rtl/match_matrix_sequencer.sv
// Streams the N x N XNOR match matrix of each accepted vector row by row, then pulses its total
// match count; first row one cycle after acceptance, rows hold under row_ready backpressure.
module match_matrix_sequencer
    import pair_match_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N*N+1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          row_valid,
    input  logic          row_ready,
    output logic [N-1:0]  row_data,
    output logic [2:0]    row_idx,
    output logic          row_last,
    output logic          count_valid,
    output logic [CW-1:0] match_count
);

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;

    logic [N-1:0]  row_w;
    logic [3:0]    row_pop;
    logic          last_w;

    // Row is derived from the captured vector only, so in_data never reaches an output.
    pair_match_row #(.N(N)) u_row (
        .vec (vec_q),
        .idx (idx_q),
        .row (row_w)
    );

    assign row_pop = popcount8(8'(row_w));
    assign last_w  = (idx_q == 3'(N-1));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = in_data;
                    idx_d   = 3'd0;
                    acc_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (row_ready) begin
                    acc_d = acc_q + CW'(row_pop);
                    idx_d = idx_q + 3'd1;
                    if (last_w) begin
                        count_d = acc_q + CW'(row_pop);
                        idx_d   = 3'd0;
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        row_valid   = (state_q == STREAM);
        count_valid = (state_q == REPORT);
        row_idx     = idx_q;
        row_data    = '0;
        row_last    = 1'b0;
        if (state_q == STREAM) begin
            row_data = row_w;
            row_last = last_w;
        end
        match_count = count_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= 3'd0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_match_matrix_sequencer.sv
// Directed bench for match_matrix_sequencer with N=5 and hand-computed rows and counts.
module tb_match_matrix_sequencer;

    localparam int N  = 5;
    localparam int CW = 5;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          row_valid;
    logic          row_ready;
    logic [N-1:0]  row_data;
    logic [2:0]    row_idx;
    logic          row_last;
    logic          count_valid;
    logic [CW-1:0] match_count;

    int n_checks;
    int n_errors;

    match_matrix_sequencer #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .row_last    (row_last),
        .count_valid (count_valid),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams one vector through the block and checks every row, the report cycle and the
    // return to IDLE. stall_idx/abort_idx of -1 disable the stall/mid-stream reset.
    task automatic run_vector(input string name, input logic [4:0] vec,
                              input logic [4:0] rows [5], input logic [4:0] exp_cnt,
                              input int stall_idx, input int abort_idx, input bit noise,
                              input bit chain, input logic [4:0] next_vec);
        int cyc;
        cyc = 0;
        in_valid = 1'b1;
        in_data  = vec;
        step();
        cyc++;
        in_valid = noise;
        for (int i = 0; i < N; i++) begin
            if (noise) in_data = (i % 2 == 1) ? 5'b11111 : 5'b00000;
            check({name, "_row_valid"}, 32'(row_valid), 32'd1);
            check({name, "_in_ready"}, 32'(in_ready), 32'd0);
            check({name, "_row_idx"}, 32'(row_idx), 32'(i));
            check({name, "_row_data"}, 32'(row_data), 32'(rows[i]));
            check({name, "_row_last"}, 32'(row_last), (i == N-1) ? 32'd1 : 32'd0);
            check({name, "_no_count"}, 32'(count_valid), 32'd0);
            if (i == abort_idx) begin
                resetn   = 1'b0;
                in_valid = 1'b0;
                step();
                check({name, "_rst_row_valid"}, 32'(row_valid), 32'd0);
                check({name, "_rst_row_data"}, 32'(row_data), 32'd0);
                check({name, "_rst_row_idx"}, 32'(row_idx), 32'd0);
                check({name, "_rst_row_last"}, 32'(row_last), 32'd0);
                check({name, "_rst_count_valid"}, 32'(count_valid), 32'd0);
                check({name, "_rst_match_count"}, 32'(match_count), 32'd0);
                check({name, "_rst_in_ready"}, 32'(in_ready), 32'd1);
                resetn = 1'b1;
                return;
            end
            if (i == stall_idx) begin
                row_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    cyc++;
                    check({name, "_stall_idx"}, 32'(row_idx), 32'(i));
                    check({name, "_stall_data"}, 32'(row_data), 32'(rows[i]));
                    check({name, "_stall_valid"}, 32'(row_valid), 32'd1);
                    check({name, "_stall_no_count"}, 32'(count_valid), 32'd0);
                end
                row_ready = 1'b1;
            end
            step();
            cyc++;
        end
        check({name, "_count_valid"}, 32'(count_valid), 32'd1);
        check({name, "_match_count"}, 32'(match_count), 32'(exp_cnt));
        check({name, "_report_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_report_row_valid"}, 32'(row_valid), 32'd0);
        if (chain) begin
            in_valid = 1'b1;
            in_data  = next_vec;
        end else begin
            in_valid = 1'b0;
        end
        step();
        cyc++;
        check({name, "_idle_count_valid"}, 32'(count_valid), 32'd0);
        check({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({name, "_count_held"}, 32'(match_count), 32'(exp_cnt));
        check({name, "_cycles"}, 32'(cyc), (stall_idx >= 0) ? 32'd10 : 32'd7);
    endtask

    initial begin
        logic [4:0] rows_10110 [5];
        logic [4:0] rows_ones  [5];
        logic [4:0] rows_01000 [5];
        logic [4:0] rows_11100 [5];

        rows_10110 = '{5'b10110, 5'b01001, 5'b10110, 5'b10110, 5'b01001};
        rows_ones  = '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
        rows_01000 = '{5'b10111, 5'b01000, 5'b10111, 5'b10111, 5'b10111};
        rows_11100 = '{5'b11100, 5'b11100, 5'b11100, 5'b00011, 5'b00011};

        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        row_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_row_valid", 32'(row_valid), 32'd0);
        check("reset_count_valid", 32'(count_valid), 32'd0);
        check("reset_match_count", 32'(match_count), 32'd0);
        check("reset_row_data", 32'(row_data), 32'd0);
        check("reset_row_idx", 32'(row_idx), 32'd0);

        run_vector("v10110", 5'b10110, rows_10110, 5'd13, -1, -1, 1'b0, 1'b0, 5'b00000);
        run_vector("v11111", 5'b11111, rows_ones, 5'd25, -1, -1, 1'b0, 1'b0, 5'b00000);
        run_vector("v00000", 5'b00000, rows_ones, 5'd25, -1, -1, 1'b0, 1'b0, 5'b00000);
        run_vector("stall", 5'b10110, rows_10110, 5'd13, 2, -1, 1'b0, 1'b0, 5'b00000);

        // Busy source: rows must follow the first vector; 11100 is taken in the first IDLE cycle.
        run_vector("noise", 5'b01000, rows_01000, 5'd17, -1, -1, 1'b1, 1'b1, 5'b11100);
        run_vector("chained", 5'b11100, rows_11100, 5'd13, -1, -1, 1'b0, 1'b0, 5'b00000);

        run_vector("abort", 5'b10110, rows_10110, 5'd13, -1, 3, 1'b0, 1'b0, 5'b00000);
        run_vector("after_abort", 5'b01000, rows_01000, 5'd17, -1, -1, 1'b0, 1'b0, 5'b00000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/match_matrix_sequencer.md
MATCH_MATRIX_SEQUENCER -- requirements
Module: match_matrix_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 5, giving the number of single-bit inputs per vector; legal range 2..8.
REQ-002 The block SHALL have parameter CW, default $clog2(N*N+1), giving the match-count width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  source presents a vector.
REQ-006 in_data  input  N  vector; bit N-1 is element 0 (a), bit 0 is element N-1 (e).
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 row_valid  output  1  row_data/row_idx are valid.
REQ-009 row_ready  input  1  sink accepts the current row.
REQ-010 row_data  output  N  match row; bit N-1-j = XNOR(element row_idx, element j).
REQ-011 row_idx  output  3  index of the current row, 0..N-1.
REQ-012 row_last  output  1  high with row_valid when row_idx = N-1.
REQ-013 count_valid  output  1  one-cycle pulse qualifying match_count.
REQ-014 match_count  output  CW  total ones over all N*N matrix bits of the last vector.

Function
REQ-015 The FSM SHALL have three states: IDLE, STREAM and REPORT.
REQ-016 In IDLE, in_ready SHALL be 1; on in_valid&in_ready, the block SHALL register in_data, clear row_idx and the accumulator, and go to STREAM.
REQ-017 In STREAM, in_ready SHALL be 0 and row_valid SHALL be 1, so the first row appears the cycle after acceptance (latency 1).
REQ-018 In STREAM, row_data SHALL be computed from the registered vector only; in_data changes SHALL have no effect.
REQ-019 While row_valid&!row_ready, row_data, row_idx and row_last SHALL hold stable.
REQ-020 On each row handshake, the accumulator SHALL add popcount(row_data) and row_idx SHALL increment.
REQ-021 On the handshake with row_last=1, the FSM SHALL go to REPORT and load match_count with accumulator plus the last row popcount.
REQ-022 In REPORT, count_valid SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE, with in_ready=0 during the REPORT cycle.
REQ-023 match_count SHALL hold its value until the next REPORT.
REQ-024 in_valid asserted in STREAM or REPORT SHALL be ignored; no vector is queued.
REQ-025 With row_ready held at 1, one vector SHALL occupy exactly N+2 cycles from acceptance to the return to IDLE.
REQ-026 For a vector with k ones, match_count SHALL equal k*k + (N-k)*(N-k); for N=5 the range is 13..25.
REQ-027 The block SHALL be fully synchronous, with no combinational path from in_data to any output.

Reset
REQ-028 While resetn=0 at a clock edge, the block SHALL enter IDLE and clear all outputs as follows: row_valid=0, row_last=0, row_data=0, row_idx=0, count_valid=0, match_count=0; in_ready becomes 1 after the edge.
REQ-029 Reset asserted mid-STREAM or in REPORT SHALL abandon the vector with no count_valid pulse, and the block SHALL accept a new vector the first cycle resetn=1.

Structure
REQ-030 A shared package pair_match_pkg SHALL hold the state enum type (IDLE, STREAM, REPORT) and the default N constant.
REQ-031 The row computation SHALL live in a combinational sub-module pair_match_row, with inputs vector (N) and index, and output the XNOR row (N).
REQ-032 The popcount SHALL be a function in pair_match_pkg.

Verification
REQ-033 Hold resetn=0 for 2 cycles, then release: in_ready=1, row_valid=0, count_valid=0, match_count=0.
REQ-034 Apply in_data=10110 with row_ready=1: rows 10110, 01001, 10110, 10110, 01001 (idx 0..4), row_last on idx 4, count_valid next cycle with match_count=13.
REQ-035 Apply in_data=11111 and then 00000: every row is 11111 and match_count=25 for each vector.
REQ-036 Drop row_ready for 3 cycles at idx 2: row_idx=2 and row_data stable throughout, total time N+2+3 cycles, match_count unchanged vs. the no-stall case.
REQ-037 Hold in_valid=1 with alternating data during STREAM: in_ready=0, rows reflect the first vector only, and the next vector is accepted in the first IDLE cycle after REPORT.
REQ-038 Assert resetn=0 for 1 cycle at idx 3: no count_valid pulse, outputs cleared, and the next vector streams correctly.
